// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch bank controller.
//   state_e : write-sequence phases (idle, setup, enable pulse, hold, check)
//   NumReq  : number of requesters sharing the bank
//   max3    : largest of three cycle counts, sizes the phase counter
package sr_ctrl_pkg;

  localparam int unsigned NumReq = 2;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StCheck
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (purely combinational).
//   i_req      : per-requester request
//   i_last_gnt : index of the requester granted most recently
//   o_gnt      : one-hot grant (all zero when nobody requests)
//   o_gnt_id   : index of the granted requester (0 when no grant)
module rr_arb2
  import sr_ctrl_pkg::*;
(
  input  logic [NumReq-1:0] i_req,
  input  logic              i_last_gnt,
  output logic [NumReq-1:0] o_gnt,
  output logic              o_gnt_id
);

  logic w_pref;

  // The requester after the last winner gets first refusal.
  assign w_pref = ~i_last_gnt;

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = 1'b0;
    if (i_req[w_pref]) begin
      o_gnt[w_pref] = 1'b1;
      o_gnt_id      = w_pref;
    end else if (i_req[i_last_gnt]) begin
      o_gnt[i_last_gnt] = 1'b1;
      o_gnt_id          = i_last_gnt;
    end
  end

endmodule

// File: rtl/sr_latch_bank_ctrl.sv
// Write sequencer for a bank of gated SR latches shared by two requesters.
// Each accepted write drives S/R on the addressed latch for a setup window,
// pulses that latch's enable, holds S/R, then reads q back and reports.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready only while idle)
//   req_addr            : requester i address at [i*AW +: AW]
//   req_data            : requester i bit value (1 = set, 0 = reset)
//   done/done_id/err    : one-cycle completion pulse, requester id, error flag
//   lat_s/lat_r/lat_c   : per-latch S, R and enable (all registered)
//   lat_q               : per-latch readback
module sr_latch_bank_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned N_LATCH   = 8,
  parameter int unsigned AW        = $clog2(N_LATCH),  // derived, leave at default
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NumReq-1:0]    req_valid,
  output logic [NumReq-1:0]    req_ready,
  input  logic [NumReq*AW-1:0] req_addr,
  input  logic [NumReq-1:0]    req_data,
  output logic                 done,
  output logic                 done_id,
  output logic                 err,
  output logic [N_LATCH-1:0]   lat_s,
  output logic [N_LATCH-1:0]   lat_r,
  output logic [N_LATCH-1:0]   lat_c,
  input  logic [N_LATCH-1:0]   lat_q
);

  localparam int unsigned MaxCyc = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  state_e              r_state, w_state_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic [AW-1:0]       r_addr, w_addr_sel, w_addr_n;
  logic                r_data, w_data_sel, w_data_n;
  logic                r_id, w_id_n;
  logic                r_oor, w_oor_sel, w_oor_n;
  logic                r_last_gnt;
  logic [NumReq-1:0]   w_gnt;
  logic                w_gnt_id;
  logic                w_idle, w_accept, w_drive, w_q_sel;
  logic [N_LATCH-1:0]  r_lat_s, r_lat_r, r_lat_c;
  logic [N_LATCH-1:0]  w_lat_s_d, w_lat_r_d, w_lat_c_d;
  logic                r_done, r_done_id, r_err;
  logic                w_done_d, w_err_d;

  rr_arb2 u_arb (
    .i_req      (req_valid),
    .i_last_gnt (r_last_gnt),
    .o_gnt      (w_gnt),
    .o_gnt_id   (w_gnt_id)
  );

  assign w_idle     = (r_state == StIdle);
  assign req_ready  = w_idle ? w_gnt : '0;
  assign w_accept   = w_idle & (|w_gnt);
  assign w_addr_sel = w_gnt_id ? req_addr[AW +: AW] : req_addr[0 +: AW];
  assign w_data_sel = req_data[w_gnt_id];
  assign w_oor_sel  = (32'(w_addr_sel) >= N_LATCH);

  // Transaction fields as they will be after this edge.
  assign w_addr_n = w_accept ? w_addr_sel : r_addr;
  assign w_data_n = w_accept ? w_data_sel : r_data;
  assign w_id_n   = w_accept ? w_gnt_id   : r_id;
  assign w_oor_n  = w_accept ? w_oor_sel  : r_oor;

  // Phase counter counts up from 0 on every state entry.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt + CntW'(1);
    unique case (r_state)
      StIdle: begin
        w_cnt_d = '0;
        if (w_accept) w_state_d = w_oor_sel ? StCheck : StSetup;
      end
      StSetup: begin
        if (r_cnt == CntW'(SETUP_CYC - 1)) begin
          w_state_d = StPulse;
          w_cnt_d   = '0;
        end
      end
      StPulse: begin
        if (r_cnt == CntW'(PULSE_CYC - 1)) begin
          w_state_d = StHold;
          w_cnt_d   = '0;
        end
      end
      StHold: begin
        if (r_cnt == CntW'(HOLD_CYC - 1)) begin
          w_state_d = StCheck;
          w_cnt_d   = '0;
        end
      end
      StCheck: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Latch outputs are computed from the next state so that they leave flops
  // in the same cycle the state changes; S/R persist unchanged across
  // setup, pulse and hold so enable never moves together with S/R.
  always_comb begin
    w_lat_s_d = '0;
    w_lat_r_d = '0;
    w_lat_c_d = '0;
    w_q_sel   = 1'b0;
    w_drive   = (w_state_d == StSetup) || (w_state_d == StPulse) || (w_state_d == StHold);
    for (int unsigned i = 0; i < N_LATCH; i++) begin
      if (w_addr_n == AW'(i)) begin
        w_lat_s_d[i] = w_drive & w_data_n;
        w_lat_r_d[i] = w_drive & ~w_data_n;
        w_lat_c_d[i] = (w_state_d == StPulse);
        w_q_sel      = lat_q[i];
      end
    end
    w_done_d = (w_state_d == StCheck);
    // q is sampled at the hold->check edge, well after enable has fallen.
    w_err_d  = w_oor_n | (w_q_sel != w_data_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_data     <= 1'b0;
      r_id       <= 1'b0;
      r_oor      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_lat_s    <= '0;
      r_lat_r    <= '0;
      r_lat_c    <= '0;
      r_done     <= 1'b0;
      r_done_id  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_addr    <= w_addr_n;
      r_data    <= w_data_n;
      r_id      <= w_id_n;
      r_oor     <= w_oor_n;
      if (w_accept) r_last_gnt <= w_gnt_id;
      r_lat_s   <= w_lat_s_d;
      r_lat_r   <= w_lat_r_d;
      r_lat_c   <= w_lat_c_d;
      r_done    <= w_done_d;
      r_done_id <= w_done_d & w_id_n;
      r_err     <= w_done_d & w_err_d;
    end
  end

  assign lat_s   = r_lat_s;
  assign lat_r   = r_lat_r;
  assign lat_c   = r_lat_c;
  assign done    = r_done;
  assign done_id = r_done_id;
  assign err     = r_err;

endmodule

// File: tb/tb_sr_latch_bank_ctrl.sv
// Bench for sr_latch_bank_ctrl with a six-latch bank (addresses 6 and 7 are
// out of range). Outputs are compared every cycle against a timeline model
// of the write protocol, plus hand-computed waveform checks.
module tb_sr_latch_bank_ctrl;

  localparam int unsigned N  = 6;
  localparam int unsigned AW = 3;
  localparam int unsigned S  = 1;
  localparam int unsigned P  = 2;
  localparam int unsigned H  = 1;
  localparam int          LIN = S + P + H + 1;
  localparam logic [N-1:0] One = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    req_valid = '0;
  logic [1:0]    req_ready;
  logic [2*AW-1:0] req_addr = '0;
  logic [1:0]    req_data = '0;
  logic          done, done_id, err;
  logic [N-1:0]  lat_s, lat_r, lat_c, lat_q;
  logic [N-1:0]  bank_q = '0;
  logic          stuck5 = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_latch_bank_ctrl #(
    .N_LATCH   (N),
    .SETUP_CYC (S),
    .PULSE_CYC (P),
    .HOLD_CYC  (H)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .done      (done),
    .done_id   (done_id),
    .err       (err),
    .lat_s     (lat_s),
    .lat_r     (lat_r),
    .lat_c     (lat_c),
    .lat_q     (lat_q)
  );

  // Bank of level-sensitive SR latches: transparent while enable is high.
  always @(lat_s or lat_r or lat_c) begin
    for (int i = 0; i < N; i++) begin
      if (lat_c[i]) begin
        if (lat_s[i]) bank_q[i] = 1'b1;
        else if (lat_r[i]) bank_q[i] = 1'b0;
      end
    end
  end
  assign lat_q = stuck5 ? (bank_q & ~(One << 5)) : bank_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] rr(input logic [1:0] v, input logic last);
    if (last) begin
      if (v[0]) return 2'b01;
      if (v[1]) return 2'b10;
    end else begin
      if (v[1]) return 2'b10;
      if (v[0]) return 2'b01;
    end
    return 2'b00;
  endfunction

  // Timeline model: m_k counts cycles since the accepting edge.
  logic       m_busy = 1'b0;
  int         m_k = 0;
  int         m_addr = 0;
  logic       m_data = 1'b0, m_id = 1'b0, m_oor = 1'b0, m_last = 1'b1;
  logic [1:0] m_gnt;
  int         m_len, m_new_addr;

  assign m_gnt      = rr(req_valid, m_last);
  assign m_len      = m_oor ? 1 : LIN;
  assign m_new_addr = m_gnt[1] ? int'(req_addr[AW +: AW]) : int'(req_addr[0 +: AW]);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_last <= 1'b1;
    end else if (m_busy) begin
      if (m_k == m_len) m_busy <= 1'b0;
      else m_k <= m_k + 1;
    end else if (m_gnt != 2'b00) begin
      m_busy <= 1'b1;
      m_k    <= 1;
      m_id   <= m_gnt[1];
      m_last <= m_gnt[1];
      m_addr <= m_new_addr;
      m_data <= req_data[m_gnt[1]];
      m_oor  <= (m_new_addr >= N);
    end
  end

  logic [1:0]   e_ready;
  logic [N-1:0] e_s, e_r, e_c, e_hot;
  logic         e_done, e_err, e_q, e_drive;

  always_comb begin
    e_ready = m_busy ? 2'b00 : m_gnt;
    e_hot   = (m_addr < N) ? (One << m_addr) : '0;
    e_drive = m_busy && !m_oor && (m_k <= S + P + H);
    e_s     = (e_drive && m_data) ? e_hot : '0;
    e_r     = (e_drive && !m_data) ? e_hot : '0;
    e_c     = (e_drive && m_k > S && m_k <= S + P) ? e_hot : '0;
    e_done  = m_busy && (m_k == m_len);
    e_q     = (m_addr == 5 && stuck5) ? 1'b0 : m_data;
    e_err   = m_oor || (e_q != m_data);
  end

  always @(negedge clk) begin
    check("ready", req_ready, e_ready);
    check("lat_s", lat_s, e_s);
    check("lat_r", lat_r, e_r);
    check("lat_c", lat_c, e_c);
    check("done", done, e_done);
    check("at_most_one_hot", $countones(lat_s | lat_r | lat_c) <= 1, 1);
    if (e_done) begin
      check("done_id", done_id, m_id);
      check("err", err, e_err);
      if (!m_oor) check("bank_q", lat_q[m_addr], e_q);
    end
  end

  task automatic do_write(input int who, input int addr, input logic data,
                          output logic [7:0] sp, output logic [7:0] cp, output logic [7:0] dp,
                          output logic id, output logic er);
    int w;
    sp = '0; cp = '0; dp = '0; id = 1'b0; er = 1'b0;
    @(posedge clk); #1;
    req_valid      = 2'b00;
    req_valid[who] = 1'b1;
    if (who == 1) req_addr[AW +: AW] = 3'(addr);
    else req_addr[0 +: AW] = 3'(addr);
    req_data[who] = data;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!req_ready[who] && w < 20);
    check("accept_wait", req_ready[who], 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      sp[k] = (addr < N) ? (lat_s[addr] | lat_r[addr]) : |(lat_s | lat_r | lat_c);
      cp[k] = |lat_c;
      dp[k] = done;
      if (done) begin
        id = done_id;
        er = err;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [7:0] sp, cp, dp;
  logic       id, er;
  int         cnt_a, cnt_b, n, cyc;
  int         ids[6];
  int         tdn[6];

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Idle after reset: nothing moves.
    cnt_a = 0; cnt_b = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) cnt_a++;
      if (|(lat_s | lat_r | lat_c) || |req_ready) cnt_b++;
    end
    check("idle_done_count", cnt_a, 0);
    check("idle_activity", cnt_b, 0);

    // Single write, addr 3 set.
    do_write(0, 3, 1'b1, sp, cp, dp, id, er);
    check("w3_sr_pattern", sp, 8'b0000_1111);
    check("w3_c_pattern", cp, 8'b0000_0110);
    check("w3_done_pattern", dp, 8'b0001_0000);
    check("w3_done_id", id, 0);
    check("w3_err", er, 0);
    check("w3_q", lat_q[3], 1);

    // Both requesters held valid: strict alternation, one write per 6 cycles.
    pulse_reset();
    @(posedge clk); #1;
    req_valid = 2'b11;
    req_addr  = {3'd2, 3'd1};
    req_data  = 2'b01;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        ids[n] = done_id;
        tdn[n] = cyc;
        n++;
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    check("alt_count", n, 6);
    for (int i = 0; i < n; i++) check("alt_id", ids[i], i % 2);
    for (int i = 1; i < n; i++) check("alt_gap", tdn[i] - tdn[i-1], 6);
    repeat (8) @(posedge clk);
    check("alt_q1", lat_q[1], 1);
    check("alt_q2", lat_q[2], 0);

    // Out-of-range address: no bank activity, done after one cycle.
    do_write(1, 6, 1'b1, sp, cp, dp, id, er);
    check("oor_activity", sp | cp, 0);
    check("oor_done_pattern", dp, 8'b0000_0001);
    check("oor_done_id", id, 1);
    check("oor_err", er, 1);

    // Latch 5 stuck at 0.
    @(posedge clk); #1 stuck5 = 1'b1;
    do_write(0, 5, 1'b1, sp, cp, dp, id, er);
    check("stuck_set_err", er, 1);
    check("stuck_done_pattern", dp, 8'b0001_0000);
    do_write(1, 5, 1'b0, sp, cp, dp, id, er);
    check("stuck_clr_err", er, 0);
    check("stuck_clr_id", id, 1);
    @(posedge clk); #1 stuck5 = 1'b0;

    // Reset during the enable pulse.
    @(posedge clk); #1;
    req_valid = 2'b01;
    req_addr[0 +: AW] = 3'd4;
    req_data[0] = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!req_ready[0] && cyc < 20);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("pulse_c4", lat_c[4], 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_lat_async", lat_s | lat_r | lat_c, 0);
    check("rst_done", done, 0);
    repeat (2) @(posedge clk);
    req_valid = 2'b11;
    req_addr  = {3'd0, 3'd4};
    req_data  = 2'b00;
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("rst_first_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    cnt_a = 0; id = 1'b1; er = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) begin
        cnt_a++;
        id = done_id;
        er = err;
      end
    end
    check("rst_after_done_count", cnt_a, 1);
    check("rst_after_id", id, 0);
    check("rst_after_err", er, 0);
    check("rst_after_q4", lat_q[4], 0);

    // Randomised traffic with latch 5 stuck.
    @(posedge clk); #1 stuck5 = 1'b1;
    repeat (400) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom_range(0, 3));
      req_addr  = 6'($urandom);
      req_data  = 2'($urandom);
    end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (10) @(posedge clk);
    #1 stuck5 = 1'b0;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
